// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame packer: state encoding, sync-byte defaults
// and frame-length helpers.
package adc_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    localparam logic [7:0] HDR0_DEFAULT   = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT   = 8'h55;
    localparam int         NUM_CH_DEFAULT = 16;

    // Two sync bytes, sequence byte, two bytes per channel, checksum byte.
    function automatic int frame_len(input int num_ch);
        return 2 * num_ch + 4;
    endfunction

    localparam int FRAME_LEN_DEFAULT = 2 * NUM_CH_DEFAULT + 4;

endpackage

// File: rtl/adc_frame_packer.sv
// Packs one snapshot of NUM_CH 16-bit ADC channels into a sync/sequence/data/checksum
// byte frame offered to a UART transmitter over a valid/ready byte handshake.
module adc_frame_packer
    import adc_frame_pkg::*;
#(
    parameter int         NUM_CH = NUM_CH_DEFAULT,
    parameter logic [7:0] HDR0   = HDR0_DEFAULT,
    parameter logic [7:0] HDR1   = HDR1_DEFAULT
) (
    input  logic                   CLK_50M,
    input  logic                   RESET_n,
    input  logic                   SAMPLE_STB,
    input  logic [16*NUM_CH-1:0]   DATA_IN,
    output logic [7:0]             TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_READY,
    output logic                   BUSY,
    output logic [7:0]             DROP_CNT
);

    localparam int                IDX_W    = (2 * NUM_CH > 1) ? $clog2(2 * NUM_CH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2 * NUM_CH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t                     state;
    state_t                     state_nxt;
    logic [2*NUM_CH-1:0][7:0]   snapshot;
    logic [IDX_W-1:0]           idx;
    logic [7:0]                 seq;
    logic [7:0]                 csum;
    logic [7:0]                 drop_cnt;
    logic [7:0]                 data_byte;
    logic                       accept;
    logic                       capture;

    assign accept   = (state != S_IDLE) && TX_READY;
    assign capture  = (state == S_IDLE) && SAMPLE_STB;
    assign BUSY     = (state != S_IDLE);
    assign DROP_CNT = drop_cnt;

    always_ff @(posedge CLK_50M or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot bytes are stored LSB-first per channel, so flipping the index LSB
    // yields MSB-then-LSB transmit order.
    always_comb begin
        state_nxt = state;
        TX_VALID  = 1'b1;
        TX_DATA   = 8'h00;
        data_byte = snapshot[idx ^ IDX_ONE];
        case (state)
            S_IDLE: begin
                TX_VALID = 1'b0;
                if (SAMPLE_STB) state_nxt = S_HDR0;
            end
            S_HDR0: begin
                TX_DATA = HDR0;
                if (accept) state_nxt = S_HDR1;
            end
            S_HDR1: begin
                TX_DATA = HDR1;
                if (accept) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                TX_DATA = seq;
                if (accept) state_nxt = S_DATA;
            end
            S_DATA: begin
                TX_DATA = data_byte;
                if (accept && idx == LAST_IDX) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                TX_DATA = csum;
                if (accept) state_nxt = S_IDLE;
            end
            default: begin
                TX_VALID  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RESET_n) begin
        if (!RESET_n) begin
            seq      <= 8'h00;
            idx      <= '0;
            csum     <= 8'h00;
            drop_cnt <= 8'h00;
        end else begin
            if (SAMPLE_STB && state != S_IDLE && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (capture) begin
                csum <= 8'h00;
            end
            if (accept) begin
                case (state)
                    S_SEQ: begin
                        csum <= csum + seq;
                        idx  <= '0;
                    end
                    S_DATA: begin
                        csum <= csum + data_byte;
                        idx  <= (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
                    end
                    S_CSUM:  seq <= seq + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    // Snapshot is don't-care while idle, so it carries no reset.
    always_ff @(posedge CLK_50M) begin
        if (capture) begin
            snapshot <= DATA_IN;
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: table of frames plus hand-written
// drop, wrap, saturation and mid-frame reset sequences.
module tb_adc_frame_packer;
    import adc_frame_pkg::*;

    localparam int NUM_CH = NUM_CH_DEFAULT;
    localparam int W      = 16 * NUM_CH;
    localparam int FLEN   = frame_len(NUM_CH);

    logic           CLK_50M = 1'b0;
    logic           RESET_n;
    logic           SAMPLE_STB;
    logic [W-1:0]   DATA_IN;
    logic [7:0]     TX_DATA;
    logic           TX_VALID;
    logic           TX_READY;
    logic           BUSY;
    logic [7:0]     DROP_CNT;

    adc_frame_packer #(.NUM_CH(NUM_CH), .HDR0(8'hAA), .HDR1(8'h55)) dut (
        .CLK_50M    (CLK_50M),
        .RESET_n    (RESET_n),
        .SAMPLE_STB (SAMPLE_STB),
        .DATA_IN    (DATA_IN),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .DROP_CNT   (DROP_CNT)
    );

    always #5 CLK_50M = ~CLK_50M;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [15:0] base, input logic [15:0] step);
        logic [W-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[16*k +: 16] = base + step * 16'(k);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[16*k +: 16] = 16'($urandom_range(0, 65535));
        return v;
    endfunction

    function automatic logic [7:0] data_byte_of(input logic [W-1:0] d, input int j);
        int ch;
        ch = j / 2;
        return (j % 2 == 0) ? d[16*ch+8 +: 8] : d[16*ch +: 8];
    endfunction

    function automatic logic [7:0] csum_of(input logic [W-1:0] d, input logic [7:0] s);
        logic [7:0] acc;
        acc = s;
        for (int j = 0; j < 2 * NUM_CH; j++) acc = acc + data_byte_of(d, j);
        return acc;
    endfunction

    task automatic reset_dut();
        @(negedge CLK_50M);
        RESET_n    = 1'b0;
        SAMPLE_STB = 1'b0;
        TX_READY   = 1'b0;
        repeat (2) @(negedge CLK_50M);
        RESET_n = 1'b1;
        @(negedge CLK_50M);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after CSUM
    // acceptance, or early (before driving) once abort_at bytes are accepted.
    task automatic run_frame(input string name, input logic [W-1:0] d, input int pct,
                             input bit wiggle, input bit drops, input logic [7:0] exp_seq,
                             input logic [7:0] exp_csum, input int abort_at);
        logic [7:0] exp [FLEN];
        logic [7:0] prev_data;
        int         cnt;
        int         cyc;
        bit         stalled;
        bit         rdy;
        exp[0] = 8'hAA;
        exp[1] = 8'h55;
        exp[2] = exp_seq;
        for (int j = 0; j < 2 * NUM_CH; j++) exp[3+j] = data_byte_of(d, j);
        exp[FLEN-1] = exp_csum;
        SAMPLE_STB = 1'b1;
        DATA_IN    = d;
        TX_READY   = 1'b0;
        @(negedge CLK_50M);
        SAMPLE_STB = 1'b0;
        chk({name, "_lat_valid"}, 32'(TX_VALID), 32'd1);
        chk({name, "_lat_hdr0"}, 32'(TX_DATA), 32'hAA);
        cnt       = 0;
        cyc       = 0;
        stalled   = 1'b0;
        prev_data = 8'h00;
        while (cnt < FLEN && cyc < 4000) begin
            if (abort_at >= 0 && cnt == abort_at) return;
            if (stalled) begin
                chk({name, "_stall_data"}, 32'(TX_DATA), 32'(prev_data));
                chk({name, "_stall_valid"}, 32'(TX_VALID), 32'd1);
            end
            rdy        = ($urandom_range(0, 99) < pct);
            TX_READY   = rdy;
            SAMPLE_STB = drops && (cnt == 5 || cnt == 10 || cnt == 20 || cnt == FLEN - 1);
            if (wiggle) DATA_IN = rand_vec();
            if (TX_VALID && rdy) begin
                chk($sformatf("%s_byte%0d", name, cnt), 32'(TX_DATA), 32'(exp[cnt]));
                cnt++;
                stalled = 1'b0;
            end else begin
                stalled   = TX_VALID;
                prev_data = TX_DATA;
            end
            @(negedge CLK_50M);
            cyc++;
        end
        SAMPLE_STB = 1'b0;
        TX_READY   = 1'b0;
        if (cnt < FLEN) chk({name, "_timeout"}, 32'(cnt), 32'(FLEN));
        chk({name, "_end_valid"}, 32'(TX_VALID), 32'd0);
        chk({name, "_end_busy"}, 32'(BUSY), 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [15:0] base;
        logic [15:0] step;
        int         pct;
        bit         wiggle;
        logic [7:0] exp_seq;
        logic [7:0] exp_csum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"ramp_rdy",   16'h0000, 16'h0101, 100, 1'b0, 8'h00, 8'hF0};
        vecs[1] = '{"ones_wig",   16'hFFFF, 16'h0000, 100, 1'b1, 8'h01, 8'hE1};
        vecs[2] = '{"zero_p30",   16'h0000, 16'h0000,  30, 1'b0, 8'h02, 8'h02};
        vecs[3] = '{"ramp_p30",   16'h0000, 16'h0101,  30, 1'b1, 8'h03, 8'hF3};
        vecs[4] = '{"8001_p60",   16'h8001, 16'h0000,  60, 1'b0, 8'h04, 8'h14};

        RESET_n    = 1'b0;
        SAMPLE_STB = 1'b0;
        TX_READY   = 1'b0;
        DATA_IN    = '0;
        repeat (3) @(negedge CLK_50M);
        #1;
        chk("rst_valid", 32'(TX_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_data", 32'(TX_DATA), 32'h00);
        chk("rst_drop", 32'(DROP_CNT), 32'h00);
        @(negedge CLK_50M);
        RESET_n = 1'b1;
        @(negedge CLK_50M);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].name, mk(vecs[i].base, vecs[i].step), vecs[i].pct,
                      vecs[i].wiggle, 1'b0, vecs[i].exp_seq, vecs[i].exp_csum, -1);
        end
        chk("table_no_drops", 32'(DROP_CNT), 32'd0);

        // Three strobes mid-frame plus one on the CSUM-accept cycle.
        reset_dut();
        run_frame("drops", mk(16'h0000, 16'h0101), 100, 1'b0, 1'b1, 8'h00, 8'hF0, -1);
        chk("drop_cnt_4", 32'(DROP_CNT), 32'd4);
        run_frame("after_drops", mk(16'h0000, 16'h0101), 100, 1'b0, 1'b0, 8'h01, 8'hF1, -1);

        // Sequence counter wrap over 257 frames.
        reset_dut();
        for (int f = 0; f < 257; f++) begin
            run_frame($sformatf("wrap%0d", f), mk(16'h0000, 16'h0101), 100, 1'b0, 1'b0,
                      8'(f), csum_of(mk(16'h0000, 16'h0101), 8'(f)), -1);
        end

        // Drop counter saturation: strobe held high through a fully stalled frame.
        reset_dut();
        SAMPLE_STB = 1'b1;
        DATA_IN    = mk(16'h0000, 16'h0101);
        TX_READY   = 1'b0;
        @(negedge CLK_50M);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK_50M);
            if (i == 253) chk("drop_254", 32'(DROP_CNT), 32'd254);
            if (i == 254) chk("drop_255", 32'(DROP_CNT), 32'd255);
        end
        chk("drop_sat", 32'(DROP_CNT), 32'd255);
        chk("sat_hold_data", 32'(TX_DATA), 32'hAA);
        chk("sat_hold_valid", 32'(TX_VALID), 32'd1);
        SAMPLE_STB = 1'b0;

        // Reset after the 10th data byte is accepted.
        reset_dut();
        run_frame("pre_rst", mk(16'h0000, 16'h0101), 100, 1'b0, 1'b0, 8'h00, 8'hF0, 13);
        chk("pre_rst_valid", 32'(TX_VALID), 32'd1);
        RESET_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(TX_VALID), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_data", 32'(TX_DATA), 32'h00);
        @(negedge CLK_50M);
        RESET_n  = 1'b1;
        TX_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_50M);
            chk("midrst_no_trailing", 32'(TX_VALID), 32'd0);
        end
        TX_READY = 1'b0;
        run_frame("post_rst", mk(16'h0000, 16'h0101), 100, 1'b0, 1'b0, 8'h00, 8'hF0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
